// File: rtl/psec_spi_pkg.sv
// Shared constants, FSM state encodings and address classification for the
// PSEC SPI configuration register bank.
package psec_spi_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    // Frame FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // How an address behaves for reads and writes
    typedef enum logic [1:0] {
        K_RW   = 2'd0,
        K_INST = 2'd1,
        K_STAT = 2'd2,
        K_NONE = 2'd3
    } addr_kind_t;

    // Classify an address. The instruction address wins over the status
    // address, and both win over the plain implemented-register range.
    function automatic addr_kind_t addr_kind(
        input logic [31:0] addr,
        input logic [31:0] num_regs,
        input logic [31:0] inst_addr,
        input logic [31:0] stat_addr
    );
        addr_kind_t k;
        if (addr == inst_addr) begin
            k = K_INST;
        end else if (addr == stat_addr) begin
            k = K_STAT;
        end else if (addr < num_regs) begin
            k = K_RW;
        end else begin
            k = K_NONE;
        end
        return k;
    endfunction

endpackage

// File: rtl/psec_spi_frame.sv
// SPI frame engine: command/data FSM, bit counter, rx/tx shifters,
// address latch with auto-increment and truncated-frame error counter.
// The host presents one bit per spi_clk rising edge while cs is low.
module psec_spi_frame
    import psec_spi_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              spi_clk,
    input  logic              rstn,
    input  logic              cs,
    input  logic              pico,
    input  logic [DATA_W-1:0] rdata,
    output logic              word_valid,
    output logic [DATA_W-1:0] word,
    output logic [ADDR_W-1:0] addr,
    output logic              is_write,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              poci,
    output logic [7:0]        err_cnt
);

    localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-2:0] rx_r;
    logic [DATA_W-2:0] tx_r;
    logic [ADDR_W-1:0] addr_r;
    logic              is_write_r;
    logic              poci_r;
    logic [7:0]        err_cnt_r;

    logic              cmd_last_s;
    logic              word_last_s;
    logic              trunc_s;
    logic [DATA_W-1:0] word_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              load_s;

    // Decode the current edge: last command bit, last word bit, truncation,
    // and the address whose read data must be loaded on this edge.
    always_comb begin
        cmd_last_s  = 1'b0;
        word_last_s = 1'b0;
        trunc_s     = 1'b0;
        word_s      = {rx_r, pico};
        rd_addr_s   = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (state_r == ST_CMD) begin
            cmd_last_s = (bit_cnt_r == CNT_W'(ADDR_W));
            rd_addr_s  = {addr_r[ADDR_W-2:0], pico};
            trunc_s    = 1'b1;
        end else if (state_r == ST_DATA) begin
            word_last_s = (bit_cnt_r == CNT_W'(DATA_W - 1));
            trunc_s     = (bit_cnt_r != {CNT_W{1'b0}});
        end else begin
            cmd_last_s  = 1'b0;
            word_last_s = 1'b0;
            trunc_s     = 1'b0;
        end
    end

    assign load_s = !cs && !is_write_r && (cmd_last_s || word_last_s);

    // Frame FSM, counters, shifters and address tracking
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= {CNT_W{1'b0}};
            rx_r       <= {(DATA_W-1){1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            is_write_r <= 1'b0;
        end else if (cs) begin
            // cs high always ends the frame; nothing is committed on this edge
            state_r   <= ST_IDLE;
            bit_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_CMD;
                    is_write_r <= pico;
                    bit_cnt_r  <= CNT_W'(1);
                end
                ST_CMD: begin
                    addr_r <= {addr_r[ADDR_W-2:0], pico};
                    if (cmd_last_s) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    rx_r <= word_s[DATA_W-2:0];
                    if (word_last_s) begin
                        bit_cnt_r <= {CNT_W{1'b0}};
                        addr_r    <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Read data serialiser: load on command end / word end, else shift MSB first
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            poci_r <= 1'b0;
            tx_r   <= {(DATA_W-1){1'b0}};
        end else if (load_s) begin
            poci_r <= rdata[DATA_W-1];
            tx_r   <= rdata[DATA_W-2:0];
        end else if (!cs && !is_write_r && (state_r == ST_DATA)) begin
            poci_r <= tx_r[DATA_W-2];
            tx_r   <= tx_r << 1;
        end else begin
            poci_r <= 1'b0;
        end
    end

    // Saturating count of frames ended mid-command or mid-word
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_r <= 8'd0;
        end else if (cs && trunc_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign word_valid = !cs && word_last_s;
    assign word       = word_s;
    assign addr       = addr_r;
    assign is_write   = is_write_r;
    assign rd_addr    = rd_addr_s;
    assign poci       = poci_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: rtl/psec_spi_regbank.sv
// PSEC SPI configuration register bank: register array, address decode,
// per-register write strobes, self-clearing instruction pulses and readback mux.
module psec_spi_regbank
    import psec_spi_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REGS  = 16,
    parameter int INST_ADDR = 3,
    parameter int STAT_ADDR = 10,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       spi_clk,
    input  logic                       rstn,
    input  logic                       cs,
    input  logic                       pico,
    output logic                       poci_spi,
    input  logic [DATA_W-1:0]          status_i,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_strobe_o,
    output logic [DATA_W-1:0]          inst_pulse_o,
    output logic [7:0]                 frame_err_cnt
);

    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [NUM_REGS-1:0] wr_strobe_r;
    logic [DATA_W-1:0]   inst_pulse_r;

    logic                word_valid_s;
    logic [DATA_W-1:0]   word_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                is_write_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [DATA_W-1:0]   rdata_s;
    logic [DATA_W-1:0]   rd_reg_s;
    logic [NUM_REGS-1:0] wr_sel_s;
    logic                inst_sel_s;
    addr_kind_t          wr_kind_s;
    addr_kind_t          rd_kind_s;

    psec_spi_frame #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_frame (
        .spi_clk    (spi_clk),
        .rstn       (rstn),
        .cs         (cs),
        .pico       (pico),
        .rdata      (rdata_s),
        .word_valid (word_valid_s),
        .word       (word_s),
        .addr       (addr_s),
        .is_write   (is_write_s),
        .rd_addr    (rd_addr_s),
        .poci       (poci_spi),
        .err_cnt    (frame_err_cnt)
    );

    assign wr_kind_s = addr_kind(32'(addr_s), 32'(NUM_REGS), 32'(INST_ADDR), 32'(STAT_ADDR));
    assign rd_kind_s = addr_kind(32'(rd_addr_s), 32'(NUM_REGS), 32'(INST_ADDR), 32'(STAT_ADDR));

    // Write decode: one-hot register select and instruction select for this edge
    always_comb begin
        wr_sel_s   = {NUM_REGS{1'b0}};
        inst_sel_s = 1'b0;
        if (word_valid_s && is_write_s) begin
            inst_sel_s = (wr_kind_s == K_INST);
            for (int a = 0; a < NUM_REGS; a++) begin
                wr_sel_s[a] = (wr_kind_s == K_RW) && (32'(addr_s) == 32'(a));
            end
        end else begin
            wr_sel_s   = {NUM_REGS{1'b0}};
            inst_sel_s = 1'b0;
        end
    end

    // Readback mux; status is sampled live at load time
    always_comb begin
        rd_reg_s = {DATA_W{1'b0}};
        rdata_s  = {DATA_W{1'b0}};
        for (int a = 0; a < NUM_REGS; a++) begin
            if (32'(rd_addr_s) == 32'(a)) begin
                rd_reg_s = regs_r[a];
            end else begin
                rd_reg_s = rd_reg_s;
            end
        end
        case (rd_kind_s)
            K_RW:    rdata_s = rd_reg_s;
            K_STAT:  rdata_s = status_i;
            default: rdata_s = {DATA_W{1'b0}};
        endcase
    end

    // Register array with per-word reset image
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                regs_r[a] <= RESET_VAL[a*DATA_W +: DATA_W];
            end
        end else begin
            for (int a = 0; a < NUM_REGS; a++) begin
                if (wr_sel_s[a]) begin
                    regs_r[a] <= word_s;
                end else begin
                    regs_r[a] <= regs_r[a];
                end
            end
        end
    end

    // One-cycle write strobes and instruction pulses following a commit
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            wr_strobe_r  <= {NUM_REGS{1'b0}};
            inst_pulse_r <= {DATA_W{1'b0}};
        end else begin
            wr_strobe_r  <= wr_sel_s;
            inst_pulse_r <= inst_sel_s ? word_s : {DATA_W{1'b0}};
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_W +: DATA_W] = regs_r[g];
    end

    assign wr_strobe_o  = wr_strobe_r;
    assign inst_pulse_o = inst_pulse_r;

endmodule

// File: tb/tb_psec_spi_regbank.sv
// Self-checking bench for psec_spi_regbank: host-side SPI driver, scoreboard
// of expected read words, and strobe/pulse monitoring in the bit driver.
module tb_psec_spi_regbank;

    logic         spi_clk;
    logic         rstn;
    logic         cs;
    logic         pico;
    logic         poci_spi;
    logic [7:0]   status_i;
    logic [127:0] regs_o;
    logic [15:0]  wr_strobe_o;
    logic [7:0]   inst_pulse_o;
    logic [7:0]   frame_err_cnt;

    localparam logic [127:0] RV = {112'h0, 8'h2A, 8'h00};

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t         sb_q[$];
    int           n_tests;
    int           n_fail;
    int           strobe_cnt [16];
    int           inst_cnt;
    logic [7:0]   inst_seen;
    logic         obs_bit;
    logic [127:0] snap;

    psec_spi_regbank #(
        .ADDR_W    (7),
        .DATA_W    (8),
        .NUM_REGS  (16),
        .INST_ADDR (3),
        .STAT_ADDR (10),
        .RESET_VAL (RV)
    ) dut (
        .spi_clk       (spi_clk),
        .rstn          (rstn),
        .cs            (cs),
        .pico          (pico),
        .poci_spi      (poci_spi),
        .status_i      (status_i),
        .regs_o        (regs_o),
        .wr_strobe_o   (wr_strobe_o),
        .inst_pulse_o  (inst_pulse_o),
        .frame_err_cnt (frame_err_cnt)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One SPI bit: sample outputs on the falling edge, then drive and wait for the rising edge
    task automatic tick(input logic b, input logic c);
        @(negedge spi_clk);
        obs_bit = poci_spi;
        for (int i = 0; i < 16; i++) begin
            if (wr_strobe_o[i]) strobe_cnt[i]++;
        end
        if (inst_pulse_o != 8'h00) begin
            inst_cnt++;
            inst_seen = inst_pulse_o;
        end
        cs   = c;
        pico = b;
        @(posedge spi_clk);
    endtask

    task automatic clr_mon();
        for (int i = 0; i < 16; i++) strobe_cnt[i] = 0;
        inst_cnt  = 0;
        inst_seen = 8'h00;
    endtask

    function automatic int strobe_total();
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += strobe_cnt[i];
        return s;
    endfunction

    function automatic logic [7:0] word_of(input logic [127:0] img, input int a);
        return img[a*8 +: 8];
    endfunction

    task automatic cmd(input logic rw, input logic [6:0] a);
        tick(rw, 1'b0);
        for (int i = 6; i >= 0; i--) tick(a[i], 1'b0);
    endtask

    task automatic wword(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) tick(w[i], 1'b0);
    endtask

    // Shift one read word in and compare it against the next scoreboard entry
    task automatic rword_chk();
        logic [7:0] r;
        exp_t       e;
        for (int i = 7; i >= 0; i--) begin
            tick(1'b0, 1'b0);
            r[i] = obs_bit;
        end
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, {24'h0, r}, {24'h0, e.val});
        end
    endtask

    task automatic end_frame();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        cs       = 1'b1;
        pico     = 1'b0;
        status_i = 8'h00;
        obs_bit  = 1'b0;
        clr_mon();

        // Reset state
        @(negedge spi_clk);
        @(negedge spi_clk);
        chk("rst_word1", {24'h0, word_of(regs_o, 1)}, 32'h2A);
        chk("rst_word0", {24'h0, word_of(regs_o, 0)}, 32'h00);
        chk("rst_poci", {31'h0, poci_spi}, 32'h0);
        chk("rst_err", {24'h0, frame_err_cnt}, 32'h0);
        rstn = 1'b1;
        end_frame();

        // Single write to addr 1
        clr_mon();
        cmd(1'b1, 7'd1);
        wword(8'h3F);
        end_frame();
        chk("wr1_word", {24'h0, word_of(regs_o, 1)}, 32'h3F);
        chk("wr1_strobe1", strobe_cnt[1], 32'd1);
        chk("wr1_strobes", strobe_total(), 32'd1);
        chk("wr1_err", {24'h0, frame_err_cnt}, 32'h0);

        // Burst write from addr 5
        clr_mon();
        cmd(1'b1, 7'd5);
        wword(8'hA5);
        wword(8'h5A);
        wword(8'hFF);
        end_frame();
        chk("burst_w5", {24'h0, word_of(regs_o, 5)}, 32'hA5);
        chk("burst_w6", {24'h0, word_of(regs_o, 6)}, 32'h5A);
        chk("burst_w7", {24'h0, word_of(regs_o, 7)}, 32'hFF);
        chk("burst_w8", {24'h0, word_of(regs_o, 8)}, 32'h00);
        chk("burst_s5", strobe_cnt[5], 32'd1);
        chk("burst_s7", strobe_cnt[7], 32'd1);
        chk("burst_strobes", strobe_total(), 32'd3);

        // Readback of addr 1, then status read bursting into addr 11
        sb_q.push_back('{"rd_word1", 8'h3F});
        cmd(1'b0, 7'd1);
        rword_chk();
        end_frame();
        cmd(1'b1, 7'd11);
        wword(8'h12);
        end_frame();
        status_i = 8'hC3;
        sb_q.push_back('{"rd_stat", 8'hC3});
        sb_q.push_back('{"rd_word11", 8'h12});
        cmd(1'b0, 7'd10);
        rword_chk();
        rword_chk();
        end_frame();
        chk("rd_err", {24'h0, frame_err_cnt}, 32'h0);

        // Instruction register pulse and readback
        clr_mon();
        cmd(1'b1, 7'd3);
        wword(8'h06);
        end_frame();
        chk("inst_val", {24'h0, inst_seen}, 32'h06);
        chk("inst_cycles", inst_cnt, 32'd1);
        chk("inst_idle", {24'h0, inst_pulse_o}, 32'h00);
        chk("inst_nostrobe", strobe_total(), 32'd0);
        sb_q.push_back('{"rd_inst", 8'h00});
        cmd(1'b0, 7'd3);
        rword_chk();
        end_frame();

        // Truncated frames and unimplemented-address write
        snap = regs_o;
        clr_mon();
        cmd(1'b1, 7'd2);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        end_frame();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        end_frame();
        cmd(1'b1, 7'd20);
        wword(8'hAA);
        end_frame();
        chk("abort_err", {24'h0, frame_err_cnt}, 32'd2);
        chk("abort_regs_lo", snap[63:0] == regs_o[63:0], 32'd1);
        chk("abort_regs_hi", snap[127:64] == regs_o[127:64], 32'd1);
        chk("abort_strobes", strobe_total(), 32'd0);
        sb_q.push_back('{"rd_addr20", 8'h00});
        cmd(1'b0, 7'd20);
        rword_chk();
        end_frame();
        chk("rd20_err", {24'h0, frame_err_cnt}, 32'd2);

        // cs rises on the last data bit: no commit, counted as an error
        clr_mon();
        cmd(1'b1, 7'd4);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
        end_frame();
        chk("race_word4", {24'h0, word_of(regs_o, 4)}, 32'h00);
        chk("race_strobes", strobe_total(), 32'd0);
        chk("race_err", {24'h0, frame_err_cnt}, 32'd3);

        // Reset mid-frame discards the partial frame
        cmd(1'b1, 7'd1);
        tick(1'b1, 1'b0);
        @(negedge spi_clk);
        rstn = 1'b0;
        cs   = 1'b1;
        @(negedge spi_clk);
        chk("mrst_word1", {24'h0, word_of(regs_o, 1)}, 32'h2A);
        chk("mrst_word5", {24'h0, word_of(regs_o, 5)}, 32'h00);
        chk("mrst_err", {24'h0, frame_err_cnt}, 32'h0);
        rstn = 1'b1;
        end_frame();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
